// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the round-robin grant index generator.
package rr_arb_pkg;

    localparam int N_REQ  = 16;  // requesters, matches the downstream 4-to-16 decoder
    localparam int IDX_W  = 4;   // log2(N_REQ)
    localparam int WAIT_W = 8;   // watchdog counter width

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating first-one finder: scans ptr+1, ptr+2, ... wrapping,
// with ptr itself checked last.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] k;

    // Walk from the farthest offset down to the nearest; the last hit wins,
    // which leaves the nearest set bit after ptr in pick.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        pick = '0;
        any  = 1'b0;
        k    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = ptr + IDX_W'(i);  // offset N_REQ wraps back to ptr itself
            if (req[k]) begin
                pick = k;
                any  = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_grant_index_gen.sv
// Round-robin arbiter over 16 requesters producing a registered index plus
// valid for a 4-to-16 decoder. A grant is held until acknowledged, withdrawn
// by its owner, or released by the watchdog after MAX_WAIT cycles.
module rr_grant_index_gen
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255  // 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             vld,
    output logic             timeout
);

    state_t              state_q,   state_d;
    logic [IDX_W-1:0]    ptr_q,     ptr_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                vld_q,     vld_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic                timeout_q, timeout_d;

    logic [N_REQ-1:0]    pick_req;
    logic [IDX_W-1:0]    pick_ptr;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    // One shared finder: IDLE searches the live request vector from ptr;
    // GRANT prepares the back-to-back pick, excluding the current owner and
    // starting just after it.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_req = req & ~(N_REQ'(1) << idx_q);
            pick_ptr = idx_q;
        end
    end

    rr_pick u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick_idx),
        .any  (pick_any)
    );

    // Next-state logic: grant issue, ack/withdraw/timeout release, watchdog count.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (pick_any) begin
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
                    wait_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    // Served requester becomes lowest priority.
                    ptr_d = idx_q;
                    if (pick_any) begin
                        idx_d  = pick_idx;
                        wait_d = '0;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (!req[idx_q]) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    // Offender loses priority, same as if it had been served.
                    vld_d     = 1'b0;
                    timeout_d = 1'b1;
                    ptr_d     = idx_q;
                    state_d   = IDLE;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            idx_q     <= '0;
            vld_q     <= 1'b0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign idx     = idx_q;
    assign vld     = vld_q;
    assign timeout = timeout_q;

endmodule : rr_grant_index_gen

// File: tb/tb_rr_grant_index_gen.sv
// Directed testbench for rr_grant_index_gen, watchdog shortened to 4 cycles.
module tb_rr_grant_index_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  idx;
    logic        vld;
    logic        timeout;

    int total  = 0;
    int passed = 0;

    rr_grant_index_gen #(.MAX_WAIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .idx     (idx),
        .vld     (vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle; inputs are then driven for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 16'hFFFF; ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (vld !== 1'b0)     $display("FAIL reset_vld c%0d: got %b want 0", c, vld);     else passed++;
            total++; if (idx !== 4'd0)     $display("FAIL reset_idx c%0d: got %0d want 0", c, idx);    else passed++;
            total++; if (timeout !== 1'b0) $display("FAIL reset_to c%0d: got %b want 0", c, timeout);  else passed++;
        end
        rst = 1'b0;
        step();
        total++; if (vld !== 1'b1) $display("FAIL first_vld: got %b want 1", vld); else passed++;
        total++; if (idx !== 4'd0) $display("FAIL first_idx: got %0d want 0", idx); else passed++;
        req = 16'h0000;
        step();  // withdraw; ptr stays 15
        total++; if (vld !== 1'b0) $display("FAIL reset_wd_vld: got %b want 0", vld); else passed++;
    endtask

    task automatic test_alternate();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd0, 4'd15, 4'd0, 4'd15};
        req = 16'h8001;
        step();
        for (int i = 0; i < 4; i++) begin
            total++; if (vld !== 1'b1)       $display("FAIL alt_vld%0d: got %b want 1", i, vld);                 else passed++;
            total++; if (idx !== exp_seq[i]) $display("FAIL alt_idx%0d: got %0d want %0d", i, idx, exp_seq[i]); else passed++;
            ack = 1'b1;
            if (i < 3) step();
        end
        ack = 1'b0; req = 16'h0000;
        step();  // withdraw of 15; ptr = 0
        total++; if (vld !== 1'b0) $display("FAIL alt_end_vld: got %b want 0", vld); else passed++;
    endtask

    task automatic test_timeout();
        req = 16'h0010; ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (vld !== 1'b1)     $display("FAIL wd_vld c%0d: got %b want 1", c, vld);     else passed++;
            total++; if (idx !== 4'd4)     $display("FAIL wd_idx c%0d: got %0d want 4", c, idx);    else passed++;
            total++; if (timeout !== 1'b0) $display("FAIL wd_to c%0d: got %b want 0", c, timeout);  else passed++;
        end
        step();
        total++; if (vld !== 1'b0)     $display("FAIL wd_rel_vld: got %b want 0", vld);     else passed++;
        total++; if (timeout !== 1'b1) $display("FAIL wd_rel_to: got %b want 1", timeout);  else passed++;
        step();  // only requester left, so it is granted again
        total++; if (timeout !== 1'b0) $display("FAIL wd_pulse_len: got %b want 0", timeout); else passed++;
        total++; if (vld !== 1'b1)     $display("FAIL wd_regrant: got %b want 1", vld);       else passed++;
        req = 16'h0000;
        step();  // withdraw; ptr = 4
    endtask

    task automatic test_ack_beats_withdraw();
        req = 16'h0020;
        step();
        total++; if (idx !== 4'd5) $display("FAIL aw_grant_idx: got %0d want 5", idx); else passed++;
        req = 16'h0009; ack = 1'b1;  // drop req[5] together with ack
        step();
        total++; if (vld !== 1'b1) $display("FAIL aw_vld: got %b want 1", vld);   else passed++;
        total++; if (idx !== 4'd0) $display("FAIL aw_idx: got %0d want 0", idx);  else passed++;
        ack = 1'b0; req = 16'h0000;
        step();  // withdraw of 0; ptr remains 5
        req = 16'h0021;  // ptr=5 -> search 6..15,0 -> 0
        step();
        total++; if (idx !== 4'd0) $display("FAIL aw_ptr_idx: got %0d want 0", idx); else passed++;
        req = 16'h0000;
        step();
    endtask

    task automatic test_withdraw();
        req = 16'h0008;
        step();
        total++; if (idx !== 4'd3) $display("FAIL wdr_grant_idx: got %0d want 3", idx); else passed++;
        req = 16'h0050;  // drop req[3], no ack
        step();
        total++; if (vld !== 1'b0)     $display("FAIL wdr_vld: got %b want 0", vld);     else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL wdr_to: got %b want 0", timeout); else passed++;
        step();  // ptr still 5 -> search starts at 6
        total++; if (idx !== 4'd6) $display("FAIL wdr_next_idx: got %0d want 6", idx); else passed++;
        ack = 1'b1; req = 16'h0000;
        step();  // ack with nobody else waiting -> idle
        total++; if (vld !== 1'b0) $display("FAIL wdr_ack_idle: got %b want 0", vld); else passed++;
        step();  // ack with vld=0 is ignored
        total++; if (vld !== 1'b0) $display("FAIL idle_ack_ign: got %b want 0", vld); else passed++;
        ack = 1'b0;
    endtask

    task automatic test_mid_grant_reset();
        req = 16'h0200;
        step();
        total++; if (idx !== 4'd9) $display("FAIL mr_grant_idx: got %0d want 9", idx); else passed++;
        req = 16'hFFFF;  // other requesters arrive; grant must not move
        step();
        total++; if (idx !== 4'd9) $display("FAIL mr_hold_idx: got %0d want 9", idx); else passed++;
        rst = 1'b1;
        step();
        total++; if (vld !== 1'b0)     $display("FAIL mr_vld: got %b want 0", vld);     else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL mr_to: got %b want 0", timeout);  else passed++;
        rst = 1'b0; req = 16'h0200;
        step();
        total++; if (idx !== 4'd9) $display("FAIL mr_after_idx: got %0d want 9", idx); else passed++;
        total++; if (vld !== 1'b1) $display("FAIL mr_after_vld: got %b want 1", vld);  else passed++;
        req = 16'h0000;
        step();
        req = 16'h0202;  // ptr=15 -> bit 1 found before bit 9
        step();
        total++; if (idx !== 4'd1) $display("FAIL mr_ptr_idx: got %0d want 1", idx); else passed++;
    endtask

    initial begin
        rst = 1'b1; req = '0; ack = 1'b0;
        test_reset();
        test_alternate();
        test_timeout();
        test_ack_beats_withdraw();
        test_withdraw();
        test_mid_grant_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_rr_grant_index_gen
